// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command feeder: opcode map, text geometry and feeder FSM states.
package gpu_pkg;

    localparam logic [15:0] OP_INIT = 16'h00C0;
    localparam logic [15:0] OP_PUTC = 16'h00C1;
    localparam logic [15:0] OP_BKSP = 16'h00C2;
    localparam logic [15:0] OP_SETY = 16'h00C3;
    localparam logic [15:0] OP_SETX = 16'h00C4;
    localparam logic [15:0] OP_CLS  = 16'h00C5;
    localparam logic [15:0] OP_NL   = 16'h00C6;

    localparam int TEXT_COLS = 40;
    localparam int TEXT_ROWS = 25;

    typedef enum logic [1:0] {
        S_CMD   = 2'd0,
        S_PARAM = 2'd1,
        S_GAP   = 2'd2
    } feeder_state_t;

    function automatic logic cmd_is_valid(input logic [15:0] cmd);
        return (cmd >= OP_INIT) && (cmd <= OP_NL);
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous 32-bit command FIFO ({cmd, param}); DEPTH must be a power of two so pointers wrap naturally.
module gpu_cmd_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [31:0]            i_din,
    input  logic                   i_pop,
    output logic [31:0]            o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_level == LVL_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/gpu_cmd_feeder.sv
// Serialises queued {cmd, param} pairs into CMD/PARAM/GAP word frames on cpuline.
// Optional opcode validation is enabled by defining GPU_CMD_VALIDATE_EN.
module gpu_cmd_feeder
    import gpu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [15:0]            wr_cmd,
    input  logic [15:0]            wr_param,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             bad_cnt,
    output logic [15:0]            cpuline,
    output logic                   busy,
    output feeder_state_t          dbg_state
);

    feeder_state_t r_state;
    logic [15:0]   r_cpuline;
    logic [15:0]   r_frame_cmd;
    logic [15:0]   r_frame_param;
    logic          r_frame_real;
    logic          r_overflow;

    logic          w_cmd_ok;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [31:0]   w_head;
    logic [$clog2(DEPTH):0] w_level;

`ifdef GPU_CMD_VALIDATE_EN
    logic [7:0] r_bad_cnt;
    assign w_cmd_ok = cmd_is_valid(wr_cmd);
    assign bad_cnt  = r_bad_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_bad_cnt <= 8'h00;
        end else if (wr_en && !w_cmd_ok && (r_bad_cnt != 8'hFF)) begin
            r_bad_cnt <= r_bad_cnt + 8'h01;
        end
    end
`else
    assign w_cmd_ok = 1'b1;
    assign bad_cnt  = 8'h00;
`endif

    // A write while full is dropped even if the head is popped on the same edge.
    assign w_push = wr_en && w_cmd_ok && !w_full && !clr;
    assign w_pop  = (r_state == S_PARAM) && r_frame_real;

    gpu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_clr   (clr),
        .i_push  (w_push),
        .i_din   ({wr_cmd, wr_param}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign full      = w_full;
    assign level     = w_level;
    assign overflow  = r_overflow;
    assign cpuline   = r_cpuline;
    assign dbg_state = r_state;
    assign busy      = !w_empty || ((r_state != S_CMD) && r_frame_real);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_cmd_ok && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // The frame is latched in S_CMD so later pushes never disturb it.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state       <= S_CMD;
            r_cpuline     <= 16'h0000;
            r_frame_cmd   <= 16'h0000;
            r_frame_param <= 16'h0000;
            r_frame_real  <= 1'b0;
        end else begin
            case (r_state)
                S_CMD: begin
                    if (!w_empty) begin
                        r_frame_cmd   <= w_head[31:16];
                        r_frame_param <= w_head[15:0];
                        r_frame_real  <= 1'b1;
                        r_cpuline     <= w_head[31:16];
                    end else begin
                        r_frame_cmd   <= 16'h0000;
                        r_frame_param <= 16'h0000;
                        r_frame_real  <= 1'b0;
                        r_cpuline     <= 16'h0000;
                    end
                    r_state <= S_PARAM;
                end
                S_PARAM: begin
                    r_cpuline <= r_frame_param;
                    r_state   <= (r_frame_cmd != 16'h0000) ? S_GAP : S_CMD;
                end
                S_GAP: begin
                    r_cpuline <= 16'h0000;
                    r_state   <= S_CMD;
                end
                default: begin
                    r_cpuline <= 16'h0000;
                    r_state   <= S_CMD;
                end
            endcase
        end
    end

endmodule
